// File: rtl/md_alu.sv
// md_alu: combinational integer ALU plus a multi-cycle multiply/divide unit
// with HI/LO registers and a busy flag. Optional overflow port: ALU_OVERFLOW_EN.
module md_alu #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  input  logic             start,
  output logic [WIDTH-1:0] C,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
`ifdef ALU_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int NMAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(NMAX + 1);

  localparam logic [3:0] OP_MULT  = 4'd8;
  localparam logic [3:0] OP_MULTU = 4'd9;
  localparam logic [3:0] OP_DIV   = 4'd10;
  localparam logic [3:0] OP_DIVU  = 4'd11;
  localparam logic [3:0] OP_MTHI  = 4'd12;
  localparam logic [3:0] OP_MTLO  = 4'd13;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  // Combinational ops
  logic [WIDTH-1:0] c_r;
  always_comb begin
    c_r = '0;
    case (ALUOp)
      4'd0: c_r = A + B;
      4'd1: c_r = A - B;
      4'd2: c_r = A & B;
      4'd3: c_r = A | B;
      4'd4: c_r = A >> B[SHW-1:0];
      4'd5: c_r = $signed(A) >>> B[SHW-1:0];
      4'd6: c_r = A << B[SHW-1:0];
      4'd7: c_r = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: c_r = '0;
    endcase
  end
  assign C = c_r;

`ifdef ALU_OVERFLOW_EN
  assign overflow = (ALUOp == 4'd0) ? ((A[WIDTH-1] == B[WIDTH-1]) && (c_r[WIDTH-1] != A[WIDTH-1])) :
                    (ALUOp == 4'd1) ? ((A[WIDTH-1] != B[WIDTH-1]) && (c_r[WIDTH-1] != A[WIDTH-1])) :
                    1'b0;
`endif

  // One shared multiplier: the low 2*WIDTH bits of the product of the
  // extended operands are correct for both signed and unsigned forms.
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  always_comb begin
    if (op_q == OP_MULT) begin
      a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
      b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    end else begin
      a_ext = {{WIDTH{1'b0}}, a_q};
      b_ext = {{WIDTH{1'b0}}, b_q};
    end
    prod = a_ext * b_ext;
  end

  // Sign-magnitude division; most-negative / -1 falls out naturally since
  // its magnitude 2^(WIDTH-1) is representable unsigned.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;
  always_comb begin
    a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
    b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    b_safe = (b_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (ALUOp)
            OP_MULT, OP_MULTU: begin
              a_d     = A;
              b_d     = B;
              op_d    = ALUOp;
              cnt_d   = CW'(MULT_CYCLES);
              state_d = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              a_d     = A;
              b_d     = B;
              op_d    = ALUOp;
              cnt_d   = CW'(DIV_CYCLES);
              state_d = S_BUSY;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (op_q == OP_MULT || op_q == OP_MULTU) begin
            {hi_d, lo_d} = prod;
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quo;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = (state_q == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_alu.sv
// Directed testbench for md_alu: combinational ops, mult/div latency and
// results, ignored starts, reset mid-operation, optional overflow.
module tb_md_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B, C, HI, LO;
  logic [3:0]  ALUOp;
  logic        start, busy;
`ifdef ALU_OVERFLOW_EN
  logic        overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc;

  always #5 clk = ~clk;

  md_alu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .ALUOp(ALUOp), .start(start),
    .C(C), .busy(busy), .HI(HI), .LO(LO)
`ifdef ALU_OVERFLOW_EN
    , .overflow(overflow)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic comb(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp, input string tag);
    @(negedge clk);
    ALUOp = op; A = a; B = b;
    #1;
    check(tag, C, exp);
  endtask

  // Present a start pulse sampled on one rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ALUOp = op; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count falling edges with busy high; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!busy) return;
      n++;
    end
    check("busy_timeout", 32'(n), 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUOp = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);

    comb(4'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
    comb(4'd4, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
    comb(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "add_wrap");
    comb(4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, "sub_wrap");
    comb(4'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, "and");
    comb(4'd3, 32'h0F0F_0000, 32'h0000_00FF, 32'h0F0F_00FF, "or");
    comb(4'd6, 32'd1, 32'h0000_003F, 32'h8000_0000, "sll_mask");
    comb(4'd7, 32'hFFFF_FFFF, 32'd5, 32'd1, "slt_neg");
    comb(4'd7, 32'd5, 32'hFFFF_FFFF, 32'd0, "slt_pos");
    comb(4'd14, 32'd3, 32'd4, 32'd0, "reserved_c");
    comb(4'd9, 32'd3, 32'd4, 32'd0, "seqop_c");

    issue(4'd8, 32'hFFFF_FFFD, 32'd7);
    wait_idle(cyc);
    check("mult_cycles", 32'(cyc), 32'd5);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFEB);

    issue(4'd9, 32'hFFFF_FFFD, 32'd7);
    wait_idle(cyc);
    check("multu_cycles", 32'(cyc), 32'd5);
    check("multu_hi", HI, 32'h0000_0006);
    check("multu_lo", LO, 32'hFFFF_FFEB);

    issue(4'd10, 32'hFFFF_FFF9, 32'd2);
    wait_idle(cyc);
    check("div_cycles", 32'(cyc), 32'd10);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    issue(4'd11, 32'd7, 32'd0);
    wait_idle(cyc);
    check("div0_cycles", 32'(cyc), 32'd10);
    check("div0_hi", HI, 32'hFFFF_FFFF);
    check("div0_lo", LO, 32'hFFFF_FFFD);

    issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(cyc);
    check("divmin_lo", LO, 32'h8000_0000);
    check("divmin_hi", HI, 32'd0);

    issue(4'd10, 32'd7, 32'hFFFF_FFFE);
    wait_idle(cyc);
    check("divneg_lo", LO, 32'hFFFF_FFFD);
    check("divneg_hi", HI, 32'd1);

    issue(4'd11, 32'd100, 32'd7);
    wait_idle(cyc);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // start with a combinational op code is ignored
    issue(4'd3, 32'd1, 32'd2);
    @(negedge clk);
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_hi", HI, 32'd2);
    check("ign_lo", LO, 32'd14);

    // mthi during busy is ignored; operand changes during busy have no effect
    issue(4'd8, 32'd3, 32'd4);
    @(negedge clk);
    check("busy_c1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    ALUOp = 4'd12; A = 32'd5; B = 32'd99; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; A = 32'd1234; B = 32'd0; ALUOp = 4'd0;
    wait_idle(cyc);
    check("mthi_busy_rest", 32'(cyc), 32'd3);
    check("mthi_ign_hi", HI, 32'd0);
    check("mthi_ign_lo", LO, 32'd12);
    issue(4'd13, 32'd9, 32'd0);
    @(negedge clk);
    check("mtlo_lo", LO, 32'd9);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    check("mtlo_hi", HI, 32'd0);

    // reset mid-divide, with a competing start
    issue(4'd12, 32'd77, 32'd0);
    issue(4'd11, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    @(negedge clk);
    reset = 1'b1; start = 1'b1; ALUOp = 4'd13; A = 32'd5;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_hi", HI, 32'd0);
    check("rstmid_lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check("rstlate_busy", {31'd0, busy}, 32'd0);
    check("rstlate_hi", HI, 32'd0);
    check("rstlate_lo", LO, 32'd0);

`ifdef ALU_OVERFLOW_EN
    comb(4'd0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, "ovf_add_c");
    check("ovf_add", {31'd0, overflow}, 32'd1);
    comb(4'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, "ovf_sub_c");
    check("ovf_sub", {31'd0, overflow}, 32'd0);
    comb(4'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, "ovf_sub2_c");
    check("ovf_sub2", {31'd0, overflow}, 32'd1);
    comb(4'd2, 32'h7FFF_FFFF, 32'd1, 32'd1, "ovf_and_c");
    check("ovf_and", {31'd0, overflow}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
